branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequencing controller for the branch execution lanes of a VLIW bundle. It takes the per-slot branch results produced in EX, picks the program-order-first taken branch, and issues a single registered redirect to fetch over a valid/ready handshake. It squashes younger slots of the same bundle and flushes wrong-path stages until the redirect is accepted and drained. It sits between the branch execute lanes and the fetch/PC unit.

## Interface
Parameters:
- NUM_SLOTS, 2, number of branch-capable slots per bundle; slot 0 is oldest in program order.
- FLUSH_CYCLES, 2, extra flush cycles after redirect acceptance; range 0–15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  a valid bundle is in EX this cycle.
- slot_branch_taken  in  NUM_SLOTS  per-slot taken flag from the branch lanes.
- slot_new_pc  in  NUM_SLOTS×32  per-slot target PC; slot i occupies bits [32i+31:32i].
- redirect_ready  in  1  fetch accepts the redirect.
- kill_mask  out  NUM_SLOTS  combinational; set bits suppress writeback of younger slots in the current bundle.
- redirect_valid  out  1  registered redirect request.
- redirect_pc  out  32  registered redirect target.
- flush  out  1  squash the IF/ID/EX wrong-path contents.
- busy  out  1  controller is not in IDLE.
- taken_count  out  32  statistics output (see Configuration).
- stall_count  out  32  statistics output (see Configuration).

## Operation
- States: IDLE, REDIRECT, FLUSH. Reset state is IDLE.
- IDLE, with ex_valid=1 and any taken bit set:
  - The winner w is the lowest taken slot index.
  - kill_mask has every bit above w set, in the same cycle.
  - slot_new_pc[w] is latched into redirect_pc, and the FSM moves to REDIRECT.
- IDLE with no taken branch, or with ex_valid=0: kill_mask=0 and the FSM stays in IDLE.
- REDIRECT:
  - redirect_valid=1 and flush=1.
  - redirect_pc is held stable until the handshake.
  - When redirect_valid & redirect_ready: go to FLUSH and load the counter with FLUSH_CYCLES. If FLUSH_CYCLES=0, go directly to IDLE.
- FLUSH:
  - flush=1 and redirect_valid=0.
  - The counter decrements each cycle; at count 1 the FSM moves to IDLE.
- In REDIRECT and FLUSH, ex_valid and slot_branch_taken are ignored (wrong path) and kill_mask=0.
- busy=1 in REDIRECT and FLUSH.
- The target PC is passed through unchanged. No arithmetic is done on the PC.

## Timing
- Reset values: redirect_valid=0, redirect_pc=0, flush=0, busy=0, kill_mask=0, taken_count=0, stall_count=0, FSM=IDLE, flush counter=0.
- Branch resolved in cycle T gives redirect_valid=1 and flush=1 in T+1. Latency is 1 cycle.
- If redirect_ready=1 in T+1, the handshake completes in T+1. flush then stays high for T+2…T+1+FLUSH_CYCLES, and the FSM is in IDLE at T+2+FLUSH_CYCLES.
- If redirect_ready stays low, REDIRECT holds indefinitely. redirect_valid must not drop and redirect_pc must not change.
- With FLUSH_CYCLES=0, a new branch is resolvable in the cycle after the handshake.
- Several taken slots in one bundle: only the lowest index wins, and there is exactly one redirect.
- If rst_n is asserted in any state, all outputs and state go to reset values immediately. A pending redirect is dropped.

## Configuration
BR_REDIRECT_STATS_EN controls the statistics counters.

With the macro defined:
- taken_count increments on every accepted redirect handshake.
- stall_count increments on every cycle in REDIRECT with redirect_ready=0.
- Both counters saturate at 32'hFFFFFFFF.

Without the macro: both outputs are tied to 0 and no counter flops are built.

## Test plan
- ex_valid=1, taken=2'b01, pc0=32'h0000_1000, redirect_ready=1:
  - T+1: redirect_valid=1, redirect_pc=32'h0000_1000, flush=1.
  - flush stays 1 through T+3; busy=0 at T+4.
- taken=2'b11, pc0=32'h200, pc1=32'h300: kill_mask=2'b10 in T, and redirect_pc=32'h200.
- redirect_ready held 0 for 5 cycles after the redirect is raised:
  - redirect_valid and redirect_pc stay stable.
  - A taken branch injected meanwhile is ignored.
  - With stats enabled, stall_count=5.
- FLUSH_CYCLES=0: the handshake in T+1 gives IDLE in T+2, and a new branch in T+2 gives redirect_valid in T+3.
- rst_n pulled low mid-REDIRECT: redirect_valid=0, flush=0, busy=0 asynchronously. After release, there is no redirect until a new taken branch.
- 3 taken branches with stats enabled: taken_count=3. A build without BR_REDIRECT_STATS_EN reads taken_count=0.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// Bundle-side bus for branch_redirect_ctrl: EX branch results in, fetch redirect out.
// master = controller view, slave = EX/fetch environment view.
interface branch_redirect_ctrl_if #(
  parameter int NUM_SLOTS = 2
);
  logic                       ex_valid;
  logic [NUM_SLOTS-1:0]       slot_branch_taken;
  logic [NUM_SLOTS-1:0][31:0] slot_new_pc;
  logic                       redirect_ready;
  logic [NUM_SLOTS-1:0]       kill_mask;
  logic                       redirect_valid;
  logic [31:0]                redirect_pc;
  logic                       flush;
  logic                       busy;
  logic [31:0]                taken_count;
  logic [31:0]                stall_count;

  modport master (
    input  ex_valid, slot_branch_taken, slot_new_pc, redirect_ready,
    output kill_mask, redirect_valid, redirect_pc, flush, busy, taken_count, stall_count
  );

  modport slave (
    output ex_valid, slot_branch_taken, slot_new_pc, redirect_ready,
    input  kill_mask, redirect_valid, redirect_pc, flush, busy, taken_count, stall_count
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Picks the oldest taken branch of a VLIW bundle, issues one registered redirect to fetch
// and flushes wrong-path stages. Statistics counters exist only with BR_REDIRECT_STATS_EN.
module branch_redirect_ctrl #(
  parameter int NUM_SLOTS    = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_redirect_ctrl_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

  state_t               r_state, w_next;
  logic [3:0]           r_cnt, w_cnt_nxt;
  logic [31:0]          r_pc, w_pc_nxt;
  logic [NUM_SLOTS:0]   w_older;
  logic [NUM_SLOTS-1:0] w_win;
  logic [31:0]          w_win_pc;
  logic                 w_resolve;
  logic                 w_handshake;

  // w_older[i]: some slot older than i is taken, so slot i is younger than the winner
  assign w_older[0] = 1'b0;
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign w_older[g+1] = w_older[g] | bus.slot_branch_taken[g];
    assign w_win[g]     = bus.slot_branch_taken[g] & ~w_older[g];
  end

  always_comb begin
    w_win_pc = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      w_win_pc = w_win_pc | (bus.slot_new_pc[i] & {32{w_win[i]}});
  end

  assign w_resolve   = (r_state == S_IDLE) && bus.ex_valid && w_older[NUM_SLOTS];
  assign w_handshake = (r_state == S_REDIRECT) && bus.redirect_ready;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_pc_nxt  = r_pc;
    case (r_state)
      S_IDLE: begin
        if (w_resolve) begin
          w_next   = S_REDIRECT;
          w_pc_nxt = w_win_pc;
        end
      end
      S_REDIRECT: begin
        if (bus.redirect_ready) begin
          if (FLUSH_CYCLES == 0) begin
            w_next = S_IDLE;
          end else begin
            w_next    = S_FLUSH;
            w_cnt_nxt = 4'(FLUSH_CYCLES);
          end
        end
      end
      S_FLUSH: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_next    = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pc    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  assign bus.kill_mask      = ((r_state == S_IDLE) && bus.ex_valid) ? w_older[NUM_SLOTS-1:0] : '0;
  assign bus.redirect_valid = (r_state == S_REDIRECT);
  assign bus.redirect_pc    = r_pc;
  assign bus.flush          = (r_state != S_IDLE);
  assign bus.busy           = (r_state != S_IDLE);

`ifdef BR_REDIRECT_STATS_EN
  logic [31:0] r_taken_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_handshake && (r_taken_cnt != 32'hFFFF_FFFF))
        r_taken_cnt <= r_taken_cnt + 32'd1;
      if ((r_state == S_REDIRECT) && !bus.redirect_ready && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.taken_count = r_taken_cnt;
  assign bus.stall_count = r_stall_cnt;
`else
  assign bus.taken_count = '0;
  assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, hand sequences for stall,
// zero-flush and async reset, then randomized traffic against a behavioural model.
module tb_branch_redirect_ctrl;
`ifdef BR_REDIRECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int FC0 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.NUM_SLOTS(2)) if0 ();
  branch_redirect_ctrl_if #(.NUM_SLOTS(2)) if1 ();

  branch_redirect_ctrl #(.NUM_SLOTS(2), .FLUSH_CYCLES(FC0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  branch_redirect_ctrl #(.NUM_SLOTS(2), .FLUSH_CYCLES(0))   dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of dut0: pending redirect, remaining flush cycles, stats.
  bit          m_pend;
  logic [31:0] m_pc;
  int          m_left;
  logic [31:0] m_taken, m_stall;

  task automatic model_reset();
    m_pend = 0; m_pc = '0; m_left = 0; m_taken = '0; m_stall = '0;
  endtask

  function automatic logic [1:0] exp_kill(input logic ev, input logic [1:0] tk, input bit bsy);
    int t, low;
    t = int'(tk);
    if (bsy || !ev || t == 0) return 2'b00;
    low = t & (-t);
    return 2'(~((low << 1) - 1) & 3);
  endfunction

  task automatic model_step();
    if (m_pend) begin
      if (if0.redirect_ready) begin
        m_pend = 0;
        m_left = FC0;
        if (m_taken != 32'hFFFF_FFFF) m_taken++;
      end else if (m_stall != 32'hFFFF_FFFF) m_stall++;
    end else if (m_left > 0) begin
      m_left--;
    end else if (if0.ex_valid && if0.slot_branch_taken != 0) begin
      m_pend = 1;
      for (int i = 1; i >= 0; i--)
        if (if0.slot_branch_taken[i]) m_pc = if0.slot_new_pc[i];
    end
  endtask

  task automatic drive(input logic ev, input logic [1:0] tk, input logic [31:0] p0,
                       input logic [31:0] p1, input logic rdy);
    @(negedge clk);
    if0.ex_valid = ev; if0.slot_branch_taken = tk;
    if0.slot_new_pc[0] = p0; if0.slot_new_pc[1] = p1;
    if0.redirect_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic check_model(input string tag);
    bit bsy;
    bsy = m_pend || (m_left > 0);
    chk({tag, ".redirect_valid"}, 32'(if0.redirect_valid), 32'(m_pend));
    chk({tag, ".redirect_pc"}, if0.redirect_pc, m_pc);
    chk({tag, ".flush"}, 32'(if0.flush), 32'(bsy));
    chk({tag, ".busy"}, 32'(if0.busy), 32'(bsy));
    chk({tag, ".kill_mask"}, 32'(if0.kill_mask),
        32'(exp_kill(if0.ex_valid, if0.slot_branch_taken, bsy)));
    chk({tag, ".taken_count"}, if0.taken_count, STATS ? m_taken : 32'd0);
    chk({tag, ".stall_count"}, if0.stall_count, STATS ? m_stall : 32'd0);
  endtask

  typedef struct {
    logic ev; logic [1:0] tk; logic [31:0] p0, p1; logic rdy;
    logic rv; logic [31:0] pc; logic fl; logic bz; logic [1:0] kl;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 2'b01, 32'h1000, 32'h0,   1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 2'b10};
    tbl[1]  = '{1'b0, 2'b00, 32'h0,    32'h0,   1'b1, 1'b1, 32'h1000, 1'b1, 1'b1, 2'b00};
    tbl[2]  = '{1'b1, 2'b01, 32'h1111, 32'h0,   1'b0, 1'b0, 32'h1000, 1'b1, 1'b1, 2'b00};
    tbl[3]  = '{1'b0, 2'b00, 32'h0,    32'h0,   1'b0, 1'b0, 32'h1000, 1'b1, 1'b1, 2'b00};
    tbl[4]  = '{1'b1, 2'b11, 32'h200,  32'h300, 1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, 2'b10};
    tbl[5]  = '{1'b0, 2'b00, 32'h0,    32'h0,   1'b0, 1'b1, 32'h200,  1'b1, 1'b1, 2'b00};
    tbl[6]  = '{1'b0, 2'b00, 32'h0,    32'h0,   1'b1, 1'b1, 32'h200,  1'b1, 1'b1, 2'b00};
    tbl[7]  = '{1'b0, 2'b00, 32'h0,    32'h0,   1'b0, 1'b0, 32'h200,  1'b1, 1'b1, 2'b00};
    tbl[8]  = '{1'b0, 2'b00, 32'h0,    32'h0,   1'b0, 1'b0, 32'h200,  1'b1, 1'b1, 2'b00};
    tbl[9]  = '{1'b1, 2'b10, 32'h0,    32'hABC, 1'b1, 1'b0, 32'h200,  1'b0, 1'b0, 2'b00};
    tbl[10] = '{1'b0, 2'b00, 32'h0,    32'h0,   1'b1, 1'b1, 32'hABC,  1'b1, 1'b1, 2'b00};
    tbl[11] = '{1'b0, 2'b00, 32'h0,    32'h0,   1'b0, 1'b0, 32'hABC,  1'b1, 1'b1, 2'b00};
    tbl[12] = '{1'b0, 2'b00, 32'h0,    32'h0,   1'b0, 1'b0, 32'hABC,  1'b1, 1'b1, 2'b00};
    tbl[13] = '{1'b0, 2'b00, 32'h0,    32'h0,   1'b0, 1'b0, 32'hABC,  1'b0, 1'b0, 2'b00};

    rst_n = 1'b0;
    if0.ex_valid = 0; if0.slot_branch_taken = '0; if0.slot_new_pc = '0; if0.redirect_ready = 0;
    if1.ex_valid = 0; if1.slot_branch_taken = '0; if1.slot_new_pc = '0; if1.redirect_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.redirect_valid", 32'(if0.redirect_valid), 32'd0);
    chk("rst.redirect_pc", if0.redirect_pc, 32'd0);
    chk("rst.flush", 32'(if0.flush), 32'd0);
    chk("rst.busy", 32'(if0.busy), 32'd0);
    chk("rst.kill_mask", 32'(if0.kill_mask), 32'd0);
    chk("rst.taken_count", if0.taken_count, 32'd0);
    chk("rst.stall_count", if0.stall_count, 32'd0);
    rst_n = 1'b1;

    // zero-flush instance: handshake in T+1, IDLE in T+2, new redirect in T+3
    @(negedge clk);
    if1.ex_valid = 1; if1.slot_branch_taken = 2'b01; if1.slot_new_pc[0] = 32'h40; if1.redirect_ready = 1;
    #1 chk("fc0.kill_T", 32'(if1.kill_mask), 32'h2);
    @(negedge clk);
    if1.ex_valid = 0; if1.slot_branch_taken = 2'b00;
    #1 chk("fc0.rv_T1", 32'(if1.redirect_valid), 32'd1);
    chk("fc0.pc_T1", if1.redirect_pc, 32'h40);
    @(negedge clk);
    if1.ex_valid = 1; if1.slot_branch_taken = 2'b10; if1.slot_new_pc[1] = 32'h80;
    #1 chk("fc0.busy_T2", 32'(if1.busy), 32'd0);
    chk("fc0.flush_T2", 32'(if1.flush), 32'd0);
    @(negedge clk);
    if1.ex_valid = 0; if1.slot_branch_taken = 2'b00;
    #1 chk("fc0.rv_T3", 32'(if1.redirect_valid), 32'd1);
    chk("fc0.pc_T3", if1.redirect_pc, 32'h80);
    @(negedge clk);
    #1 chk("fc0.busy_T4", 32'(if1.busy), 32'd0);

    foreach (tbl[k]) begin
      drive(tbl[k].ev, tbl[k].tk, tbl[k].p0, tbl[k].p1, tbl[k].rdy);
      chk($sformatf("vec%0d.redirect_valid", k), 32'(if0.redirect_valid), 32'(tbl[k].rv));
      chk($sformatf("vec%0d.redirect_pc", k), if0.redirect_pc, tbl[k].pc);
      chk($sformatf("vec%0d.flush", k), 32'(if0.flush), 32'(tbl[k].fl));
      chk($sformatf("vec%0d.busy", k), 32'(if0.busy), 32'(tbl[k].bz));
      chk($sformatf("vec%0d.kill_mask", k), 32'(if0.kill_mask), 32'(tbl[k].kl));
      tick();
    end
    drive(0, 2'b00, 0, 0, 0);
    chk("vec.taken_count", if0.taken_count, STATS ? 32'd3 : 32'd0);
    chk("vec.stall_count", if0.stall_count, STATS ? 32'd1 : 32'd0);
    tick();

    // fetch back-pressure: five stalled cycles with wrong-path branches injected
    drive(1, 2'b01, 32'h5000, 32'h6000, 0);
    tick();
    for (int s = 0; s < 5; s++) begin
      drive(1, 2'b11, $urandom, $urandom, 0);
      chk($sformatf("stall%0d.redirect_valid", s), 32'(if0.redirect_valid), 32'd1);
      chk($sformatf("stall%0d.redirect_pc", s), if0.redirect_pc, 32'h5000);
      chk($sformatf("stall%0d.kill_mask", s), 32'(if0.kill_mask), 32'd0);
      tick();
    end
    drive(0, 2'b00, 0, 0, 1);
    chk("stall.stall_count", if0.stall_count, STATS ? 32'd6 : 32'd0);
    check_model("stall.accept");
    tick();
    repeat (3) begin
      drive(0, 2'b00, 0, 0, 0);
      check_model("stall.drain");
      tick();
    end

    // asynchronous reset while a redirect is pending
    drive(1, 2'b01, 32'h7000, 32'h0, 0);
    tick();
    drive(0, 2'b00, 0, 0, 0);
    chk("arst.pre_rv", 32'(if0.redirect_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.redirect_valid", 32'(if0.redirect_valid), 32'd0);
    chk("arst.flush", 32'(if0.flush), 32'd0);
    chk("arst.busy", 32'(if0.busy), 32'd0);
    chk("arst.redirect_pc", if0.redirect_pc, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      drive(0, 2'b00, 0, 0, 1);
      check_model("arst.post");
      tick();
    end

    for (int r = 0; r < 400; r++) begin
      drive(($urandom % 4) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom % 2));
      check_model($sformatf("rnd%0d", r));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
